// File: rtl/xsip_telemetry_pkg.sv
// xsip_telemetry_pkg: state type, register map and byte mux shared by the telemetry I2C target
package xsip_telemetry_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_tgt_state_e;
  localparam logic [7:0] REG_SUMMARY = 8'h00;
  localparam logic [7:0] REG_TSTAMP = 8'h20;
  localparam logic [7:0] REG_STATUS = 8'h24;
  localparam logic [7:0] REG_FILL = 8'hFF;
  function automatic logic [7:0] reg_byte(input logic [255:0] sum, input logic [31:0] ts,
                                          input logic valid, input logic [7:0] ptr);
    logic [4:0] s;
    logic [1:0] t;
    s = 5'(ptr - REG_SUMMARY);
    t = 2'(ptr - REG_TSTAMP);
    return ptr < REG_TSTAMP ? sum[{s, 3'b000} +: 8] :
           ptr < REG_STATUS ? ts[{t, 3'b000} +: 8] :
           ptr == REG_STATUS ? {7'b0, valid} : REG_FILL;
  endfunction
endpackage

// File: rtl/xsip_i2c_line_cond.sv
// xsip_i2c_line_cond: synchronise and glitch-filter SCL/SDA, then flag SCL edges and START/STOP
module xsip_i2c_line_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  localparam int CW = $clog2(FILT_CYCLES + 1);
  logic [1:0] pin, filt, prev;
  assign pin = {scl_i, sda_i};
  for (genvar i = 0; i < 2; i++) begin : g_line
    logic [SYNC_STAGES-1:0] sy;
    logic [CW-1:0] cnt;
    logic f;
    assign filt[i] = f;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        sy <= '1;
        cnt <= '0;
        f <= 1'b1;
      end else begin
        sy <= {sy[SYNC_STAGES-2:0], pin[i]};
        if (sy[SYNC_STAGES-1] == f) cnt <= '0;
        else if (cnt == CW'(FILT_CYCLES - 1)) begin
          f <= ~f;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev <= 2'b11;
    else prev <= filt;
  assign sda = filt[0];
  assign scl_rise = filt[1] & ~prev[1];
  assign scl_fall = ~filt[1] & prev[1];
  assign start_det = filt[1] & prev[1] & ~filt[0] & prev[0];
  assign stop_det = filt[1] & prev[1] & filt[0] & ~prev[0];
endmodule

// File: rtl/xsip_telemetry_i2c_target.sv
// xsip_telemetry_i2c_target: I2C target serving an atomic snapshot of the telemetry summary
module xsip_telemetry_i2c_target
  import xsip_telemetry_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h4C,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         scl_i,
  input  logic         sda_i,
  output logic         sda_oe,
  input  logic [255:0] telemetry_summary,
  input  logic [31:0]  sample_timestamp,
  input  logic         telemetry_valid,
  output logic         busy,
  output logic         snap_pulse,
  output logic [15:0]  xfer_count
);
  i2c_tgt_state_e state_q, state_d;
  logic sda, scl_rise, scl_fall, start_det, stop_det;
  logic [3:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d, tx_q, tx_d, ptr_q, ptr_d;
  logic first_q, first_d, rw_q, rw_d, nack_q, nack_d, oe_d, snap_d, inc_d;
  logic [255:0] sh_sum;
  logic [31:0] sh_ts;
  logic sh_v;
  xsip_i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_cond (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i), .sda(sda),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det), .stop_det(stop_det)
  );
  assign busy = state_q != ST_IDLE;
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    shreg_d = shreg_q;
    tx_d = tx_q;
    ptr_d = ptr_q;
    first_d = first_q;
    rw_d = rw_q;
    nack_d = nack_q;
    oe_d = sda_oe;
    snap_d = 1'b0;
    inc_d = 1'b0;
    if (stop_det) begin
      state_d = ST_IDLE;
      oe_d = 1'b0;
    end else if (start_det) begin
      state_d = ST_ADDR;
      bit_d = '0;
      oe_d = 1'b0;
    end else if (scl_rise) begin
      if (state_q inside {ST_ADDR, ST_WR_BYTE}) begin
        shreg_d = {shreg_q[6:0], sda};
        bit_d = bit_q + 1'b1;
      end
      if (state_q == ST_RD_ACK) nack_d = sda;
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR: if (bit_q == 4'd8) begin
          state_d = shreg_q[7:1] == I2C_ADDR ? ST_ADDR_ACK : ST_IGNORE;
          oe_d = shreg_q[7:1] == I2C_ADDR;
          inc_d = shreg_q[7:1] == I2C_ADDR;
          rw_d = shreg_q[0];
        end
        ST_ADDR_ACK: begin
          // the first read byte comes from live inputs because the shadow loads on this same edge
          tx_d = reg_byte(telemetry_summary, sample_timestamp, telemetry_valid, ptr_q);
          snap_d = rw_q;
          first_d = 1'b1;
          bit_d = rw_q ? 4'd1 : 4'd0;
          oe_d = rw_q & ~tx_d[7];
          state_d = rw_q ? ST_RD_BYTE : ST_WR_BYTE;
        end
        ST_WR_BYTE: if (bit_q == 4'd8) begin
          oe_d = 1'b1;
          ptr_d = first_q ? shreg_q : ptr_q + 1'b1;
          first_d = 1'b0;
          state_d = ST_WR_ACK;
        end
        ST_WR_ACK: begin
          oe_d = 1'b0;
          bit_d = '0;
          state_d = ST_WR_BYTE;
        end
        ST_RD_BYTE: begin
          oe_d = bit_q == 4'd8 ? 1'b0 : ~tx_q[6];
          tx_d = {tx_q[6:0], 1'b0};
          bit_d = bit_q + 1'b1;
          ptr_d = bit_q == 4'd8 ? ptr_q + 1'b1 : ptr_q;
          state_d = bit_q == 4'd8 ? ST_RD_ACK : ST_RD_BYTE;
        end
        ST_RD_ACK: begin
          tx_d = reg_byte(sh_sum, sh_ts, sh_v, ptr_q);
          oe_d = ~nack_q & ~tx_d[7];
          bit_d = 4'd1;
          state_d = nack_q ? ST_IGNORE : ST_RD_BYTE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bit_q <= '0;
      shreg_q <= '0;
      tx_q <= '0;
      ptr_q <= '0;
      first_q <= 1'b0;
      rw_q <= 1'b0;
      nack_q <= 1'b0;
      sda_oe <= 1'b0;
      snap_pulse <= 1'b0;
      xfer_count <= '0;
      sh_sum <= '0;
      sh_ts <= '0;
      sh_v <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      shreg_q <= shreg_d;
      tx_q <= tx_d;
      ptr_q <= ptr_d;
      first_q <= first_d;
      rw_q <= rw_d;
      nack_q <= nack_d;
      sda_oe <= oe_d;
      snap_pulse <= snap_d;
      if (inc_d) xfer_count <= xfer_count + 1'b1;
      if (snap_d) begin
        sh_sum <= telemetry_summary;
        sh_ts <= sample_timestamp;
        sh_v <= telemetry_valid;
      end
    end
endmodule

// File: tb/tb_xsip_telemetry_i2c_target.sv
// tb_xsip_telemetry_i2c_target: bit-banged I2C host with a register-image reference model
module tb_xsip_telemetry_i2c_target;
  localparam int Q = 8;
  typedef struct {
    logic [7:0]  ptr;
    logic [31:0] ts;
    logic [15:0] top;
    logic        v;
    logic [31:0] exp;
    logic [7:0]  nxt;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic scl_h = 1'b1, sda_h = 1'b1, scl_gl = 1'b0, sda_gl = 1'b0;
  logic scl_i, sda_i, sda_oe, busy, snap_pulse;
  logic [255:0] summary = '0;
  logic [31:0] tstamp = '0;
  logic valid = 1'b0;
  logic [15:0] xfer_count;
  int tests = 0, fails = 0, snaps = 0;
  logic [7:0] m_ptr = '0;
  logic [15:0] m_xfer = '0;
  logic glitch = 1'b0, churn = 1'b0, seen_oe = 1'b0;
  logic [255:0] snap_sum = '0;
  vec_t vecs[5];

  assign scl_i = scl_h ^ scl_gl;
  assign sda_i = (sda_h & ~sda_oe) ^ sda_gl;
  always #5 clk = ~clk;

  xsip_telemetry_i2c_target dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .telemetry_summary(summary), .sample_timestamp(tstamp), .telemetry_valid(valid),
    .busy(busy), .snap_pulse(snap_pulse), .xfer_count(xfer_count)
  );

  function automatic logic [7:0] model_byte(input logic [255:0] s, input logic [31:0] t,
                                            input logic v, input logic [7:0] a);
    logic [7:0] img [256];
    for (int n = 0; n < 256; n++) img[n] = 8'hFF;
    for (int n = 0; n < 32; n++) img[n] = 8'(s >> (8 * n));
    for (int n = 0; n < 4; n++) img[32 + n] = 8'(t >> (8 * n));
    img[36] = {7'd0, v};
    return img[a];
  endfunction

  function automatic logic [255:0] base_sum(input logic [15:0] top);
    logic [255:0] s;
    s = '0;
    for (int n = 0; n < 30; n++) s[8 * n +: 8] = 8'(n * 7 + 3);
    s[255:240] = top;
    return s;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    wait_clk(Q);
    sda_h = b;
    if (glitch) begin
      scl_gl = 1'b1;
      wait_clk(1);
      scl_gl = 1'b0;
      wait_clk(Q - 1);
    end else wait_clk(Q);
    scl_h = 1'b1;
    wait_clk(Q / 2);
    if (glitch) begin
      sda_gl = 1'b1;
      wait_clk(1);
      sda_gl = 1'b0;
      wait_clk(Q / 2 - 1);
    end else wait_clk(Q / 2);
    r = sda_h & ~sda_oe;
    wait_clk(Q);
    scl_h = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clk(Q);
    sda_h = 1'b1;
    wait_clk(Q);
    scl_h = 1'b1;
    wait_clk(2 * Q);
    sda_h = 1'b0;
    wait_clk(2 * Q);
    scl_h = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(Q);
    sda_h = 1'b0;
    wait_clk(Q);
    scl_h = 1'b1;
    wait_clk(2 * Q);
    sda_h = 1'b1;
    wait_clk(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic last, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(1'b1, d[i]);
    bit_xfer(last, r);
  endtask

  task automatic set_ptr(input logic [7:0] p, input int extra, input logic do_stop);
    logic ack;
    i2c_start();
    write_byte({7'h4C, 1'b0}, ack);
    chk("wr_addr_ack", ack, 1);
    m_xfer++;
    write_byte(p, ack);
    chk("ptr_ack", ack, 1);
    m_ptr = p;
    for (int k = 0; k < extra; k++) begin
      write_byte(8'($urandom), ack);
      chk("extra_ack", ack, 1);
      m_ptr++;
    end
    if (do_stop) i2c_stop();
  endtask

  task automatic read_tx(input int n, input logic [255:0] s, input logic [31:0] t, input logic v,
                         input logic use_snap, output logic [31:0] w);
    logic ack;
    logic [7:0] d;
    w = '0;
    i2c_start();
    write_byte({7'h4C, 1'b1}, ack);
    chk("rd_addr_ack", ack, 1);
    m_xfer++;
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, d);
      chk($sformatf("rd_byte@%0h", m_ptr), d, model_byte(use_snap ? snap_sum : s, t, v, m_ptr));
      w = {w[23:0], d};
      m_ptr++;
    end
    wait_clk(Q);
    chk("oe_after_nack", sda_oe, 0);
    i2c_stop();
    chk("busy_after_stop", busy, 0);
    chk("xfer_count", xfer_count, m_xfer);
  endtask

  initial forever begin
    @(negedge clk);
    if (snap_pulse) begin
      snaps++;
      snap_sum = summary;
    end
    if (sda_oe) seen_oe = 1'b1;
    if (churn) for (int k = 0; k < 8; k++) summary[32 * k +: 32] = $urandom;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    logic ack, r;
    logic [31:0] w;
    logic [7:0] a;
    int c;
    vecs[0] = '{8'h20, 32'h1234_5678, 16'h0000, 1'b1, 32'h7856_3412, 8'h01};
    vecs[1] = '{8'h1E, 32'h0000_FFFF, 16'hBEEF, 1'b0, 32'hEFBE_FFFF, 8'h00};
    vecs[2] = '{8'h22, 32'hA1B2_C3D4, 16'h1357, 1'b1, 32'hB2A1_01FF, 8'hFF};
    vecs[3] = '{8'h24, 32'hDEAD_BEEF, 16'h2468, 1'b0, 32'h00FF_FFFF, 8'hFF};
    vecs[4] = '{8'hFE, 32'h0000_0000, 16'h55AA, 1'b1, 32'hFFFF_030A, 8'h11};
    wait_clk(3);
    chk("reset_sda_oe", sda_oe, 0);
    chk("reset_busy", busy, 0);
    chk("reset_snap", snap_pulse, 0);
    chk("reset_xfer", xfer_count, 0);
    rst_n = 1'b1;
    wait_clk(5);
    // wrong address: never ACKed, not counted
    seen_oe = 1'b0;
    i2c_start();
    write_byte({7'h4D, 1'b0}, ack);
    chk("nomatch_ack", ack, 0);
    write_byte(8'hA5, ack);
    chk("ignore_data_ack", ack, 0);
    chk("busy_in_ignore", busy, 1);
    i2c_stop();
    chk("nomatch_oe_seen", seen_oe, 0);
    chk("nomatch_xfer", xfer_count, 0);
    set_ptr(8'h00, 0, 1);
    chk("xfer_after_match", xfer_count, 16'd1);
    // fixed vectors: pointer write, repeated START, 4-byte read, then a 1-byte follow-up read
    for (int i = 0; i < 5; i++) begin
      summary = base_sum(vecs[i].top);
      tstamp = vecs[i].ts;
      valid = vecs[i].v;
      set_ptr(vecs[i].ptr, 0, 0);
      snaps = 0;
      read_tx(4, summary, tstamp, valid, 1'b0, w);
      chk($sformatf("vec%0d_word", i), w, vecs[i].exp);
      chk($sformatf("vec%0d_snaps", i), snaps, 1);
      read_tx(1, summary, tstamp, valid, 1'b0, w);
      chk($sformatf("vec%0d_next", i), w[7:0], vecs[i].nxt);
    end
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 8; k++) summary[32 * k +: 32] = $urandom;
      tstamp = $urandom;
      valid = 1'($urandom);
      a = $urandom_range(0, 1) ? 8'($urandom_range(24, 40)) : 8'($urandom);
      set_ptr(a, $urandom_range(0, 2), 1);
      read_tx($urandom_range(1, 4), summary, tstamp, valid, 1'b0, w);
    end
    // collector churns every cycle during a full summary read
    set_ptr(8'h00, 0, 0);
    snaps = 0;
    churn = 1'b1;
    read_tx(32, summary, tstamp, valid, 1'b1, w);
    churn = 1'b0;
    chk("churn_snaps", snaps, 1);
    // short glitches on both lines during every bit
    tstamp = 32'hCAFE_F00D;
    valid = 1'b1;
    glitch = 1'b1;
    set_ptr(8'h21, 0, 0);
    read_tx(4, summary, tstamp, valid, 1'b0, w);
    glitch = 1'b0;
    chk("glitch_word", w, 32'hF0FE_CA01);
    // reset while the target holds the address ACK
    set_ptr(8'h10, 0, 1);
    i2c_start();
    a = {7'h4C, 1'b0};
    for (int i = 7; i >= 0; i--) bit_xfer(a[i], r);
    c = 0;
    while (!sda_oe && c < 40) begin
      wait_clk(1);
      c++;
    end
    chk("ack_before_reset", sda_oe, 1);
    #3 rst_n = 1'b0;
    #1 chk("oe_async_reset", sda_oe, 0);
    m_ptr = 8'h00;
    m_xfer = '0;
    scl_h = 1'b1;
    sda_h = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(10);
    chk("busy_after_reset", busy, 0);
    chk("xfer_after_reset", xfer_count, 0);
    read_tx(1, summary, tstamp, valid, 1'b0, w);
    chk("ptr_after_reset", w[7:0], summary[7:0]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
